pool_layer: RTL and testbench

//  2x2 stride-2 signed max-pooling stage directly downstream of conv_layer.

---
 rtl/pool_layer.sv | 151 +++++++++++++++
 tb/tb_pool_layer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pool_layer.sv
// pool_layer: 2x2 stride-2 signed max-pooling between DRAM-resident feature maps
module pool_layer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 18,
  parameter int IN_BASE    = 4096,
  parameter int OUT_BASE   = 8800,
  parameter int IN_W       = 28,
  parameter int IN_H       = 28,
  parameter int CH         = 6
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  enable,
  input  logic                  dram_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [ADDR_WIDTH-1:0] addr_in,
  output logic                  dram_en_rd,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic                  dram_en_wr,
  output logic                  done
);
  localparam int OW = IN_W / 2;
  localparam int OH = IN_H / 2;
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR, DONE} state_t;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] ch_q, ch_d, orow_q, orow_d, ocol_q, ocol_d;
  logic [ADDR_WIDTH-1:0] ch_n, orow_n, ocol_n;
  logic [1:0] tap_q, tap_d;
  logic [DATA_WIDTH-1:0] max_q, max_d, max_new, data_out_q, data_out_d;
  logic [ADDR_WIDTH-1:0] addr_in_q, addr_in_d, addr_out_q, addr_out_d;
  logic rd_q, rd_d, wr_q, wr_d, done_q, done_d;
  logic ocol_wrap, orow_wrap, last;

  function automatic logic [ADDR_WIDTH-1:0] rd_addr(input logic [ADDR_WIDTH-1:0] c, r, k,
                                                     input logic [1:0] t);
    return ADDR_WIDTH'(IN_BASE) + c * ADDR_WIDTH'(IN_H * IN_W)
         + (ADDR_WIDTH'(2) * r + ADDR_WIDTH'(t[1])) * ADDR_WIDTH'(IN_W)
         + ADDR_WIDTH'(2) * k + ADDR_WIDTH'(t[0]);
  endfunction

  assign ocol_wrap = ocol_q == ADDR_WIDTH'(OW - 1);
  assign orow_wrap = orow_q == ADDR_WIDTH'(OH - 1);
  assign last      = ocol_wrap && orow_wrap && ch_q == ADDR_WIDTH'(CH - 1);
  assign ocol_n    = ocol_wrap ? '0 : ocol_q + ADDR_WIDTH'(1);
  assign orow_n    = ocol_wrap ? (orow_wrap ? '0 : orow_q + ADDR_WIDTH'(1)) : orow_q;
  assign ch_n      = (ocol_wrap && orow_wrap) ? ch_q + ADDR_WIDTH'(1) : ch_q;
  // tap 0 seeds the window; later taps replace only on strictly greater signed value
  assign max_new   = (tap_q == 2'd0 || $signed(data_in) > $signed(max_q)) ? data_in : max_q;

  // next-state and next-output decode; strobes default low so they last one cycle
  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    orow_d     = orow_q;
    ocol_d     = ocol_q;
    tap_d      = tap_q;
    max_d      = max_q;
    addr_in_d  = addr_in_q;
    addr_out_d = addr_out_q;
    data_out_d = data_out_q;
    rd_d       = 1'b0;
    wr_d       = 1'b0;
    done_d     = done_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = enable ? RD_REQ : IDLE;
        if (enable) begin
          ch_d      = '0;
          orow_d    = '0;
          ocol_d    = '0;
          tap_d     = '0;
          rd_d      = 1'b1;
          addr_in_d = rd_addr('0, '0, '0, 2'd0);
          done_d    = 1'b0;
        end
      end
      RD_REQ: state_d = RD_WAIT;
      RD_WAIT: begin
        if (dram_valid) begin
          max_d = max_new;
          if (tap_q == 2'd3) begin
            state_d    = WR;
            wr_d       = 1'b1;
            data_out_d = max_new;
            addr_out_d = ADDR_WIDTH'(OUT_BASE) + ch_q * ADDR_WIDTH'(OH * OW)
                       + orow_q * ADDR_WIDTH'(OW) + ocol_q;
          end else begin
            state_d   = RD_REQ;
            tap_d     = tap_q + 2'd1;
            rd_d      = 1'b1;
            addr_in_d = rd_addr(ch_q, orow_q, ocol_q, tap_q + 2'd1);
          end
        end
      end
      WR: begin
        if (last) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d   = RD_REQ;
          ch_d      = ch_n;
          orow_d    = orow_n;
          ocol_d    = ocol_n;
          tap_d     = '0;
          rd_d      = 1'b1;
          addr_in_d = rd_addr(ch_n, orow_n, ocol_n, 2'd0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state, counters and registered outputs; reset drops any partial window
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q    <= IDLE;
      ch_q       <= '0;
      orow_q     <= '0;
      ocol_q     <= '0;
      tap_q      <= '0;
      max_q      <= '0;
      addr_in_q  <= '0;
      addr_out_q <= '0;
      data_out_q <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      orow_q     <= orow_d;
      ocol_q     <= ocol_d;
      tap_q      <= tap_d;
      max_q      <= max_d;
      addr_in_q  <= addr_in_d;
      addr_out_q <= addr_out_d;
      data_out_q <= data_out_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      done_q     <= done_d;
    end
  end

  assign addr_in    = addr_in_q;
  assign dram_en_rd = rd_q;
  assign data_out   = data_out_q;
  assign addr_out   = addr_out_q;
  assign dram_en_wr = wr_q;
  assign done       = done_q;
endmodule

// File: tb/tb_pool_layer.sv
// tb_pool_layer: randomized DRAM-latency bench with a window-max reference model
module tb_pool_layer;
  logic        clk = 0, srst = 1, enable = 0, dram_valid = 0;
  logic [31:0] data_in = 0;
  logic [17:0] addr_in, addr_out;
  logic [31:0] data_out;
  logic        dram_en_rd, dram_en_wr, done;

  always #5 clk = ~clk;

  pool_layer dut (
    .clk(clk), .srst(srst), .enable(enable), .dram_valid(dram_valid), .data_in(data_in),
    .addr_in(addr_in), .dram_en_rd(dram_en_rd), .data_out(data_out), .addr_out(addr_out),
    .dram_en_wr(dram_en_wr), .done(done)
  );

  logic [31:0] mem    [0:4703];
  logic [31:0] exp_d  [0:1175];
  logic [17:0] exp_a  [0:1175];
  logic [17:0] wlog_a [0:8191];
  logic [31:0] wlog_d [0:8191];
  int checks = 0, passes = 0, nw = 0, base_nw = 0, drises = 0;
  bit lat_rand = 0, spur = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", name, act, act, expv, expv);
  endtask

  function automatic logic [31:0] rdw(input logic [17:0] a);
    if (a >= 18'd4096 && a < 18'd8800) return mem[int'(a) - 4096];
    return 32'hdeadbeef;
  endfunction

  // reference: each output word is the signed max of its 2x2 input block
  function automatic void build();
    for (int c = 0; c < 6; c++)
      for (int r = 0; r < 14; r++)
        for (int k = 0; k < 14; k++) begin
          int m, v, idx;
          m = 0;
          for (int t = 0; t < 4; t++) begin
            v = int'(mem[c * 784 + (2 * r + t / 2) * 28 + 2 * k + t % 2]);
            if (t == 0 || v > m) m = v;
          end
          idx = c * 196 + r * 14 + k;
          exp_d[idx] = m;
          exp_a[idx] = 18'(8800 + idx);
        end
  endfunction

  // DRAM responder plus write/done checker, all on the falling edge
  initial begin : mon
    bit pend;
    int cnt, k;
    logic [17:0] pa;
    bit dprev;
    pend = 0; cnt = 0; pa = 0; dprev = 0;
    forever begin
      @(negedge clk);
      dram_valid = 0;
      if (srst) pend = 0;
      else if (pend) begin
        chk("single_outstanding", dram_en_rd, 0);
        cnt--;
        if (cnt == 0) begin
          pend = 0;
          dram_valid = 1;
          data_in = rdw(pa);
        end
      end else if (dram_en_rd) begin
        pend = 1;
        pa = addr_in;
        cnt = lat_rand ? $urandom_range(5, 1) : 1;
      end else if (spur && (dram_en_wr || done) && $urandom_range(1, 0) == 1) begin
        dram_valid = 1;
        data_in = $urandom;
      end
      if (dram_en_wr) begin
        k = nw - base_nw;
        chk("rd_wr_exclusive", dram_en_rd, 0);
        if (k < 1176) begin
          chk("wr_addr", addr_out, exp_a[k]);
          chk("wr_data", data_out, exp_d[k]);
        end else chk("extra_write_index", k, 1175);
        if (nw < 8192) begin
          wlog_a[nw] = addr_out;
          wlog_d[nw] = data_out;
        end
        nw++;
      end
      if (done && !dprev) begin
        drises++;
        chk("done_after_last_write", nw - base_nw, 1176);
      end
      dprev = done;
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_addr_in"}, addr_in, 0);
    chk({tag, "_en_rd"}, dram_en_rd, 0);
    chk({tag, "_data_out"}, data_out, 0);
    chk({tag, "_addr_out"}, addr_out, 0);
    chk({tag, "_en_wr"}, dram_en_wr, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!done && cyc < 60000) begin
      @(negedge clk);
      cyc++;
    end
    chk("done_seen", done, 1);
  endtask

  task automatic run(input bit timed);
    int cyc;
    base_nw = nw;
    enable = 1;
    @(negedge clk);
    enable = 0;
    wait_done(cyc);
    if (timed) chk("run_cycles", cyc, 1176 * 9 + 1);
    chk("run_writes", nw - base_nw, 1176);
  endtask

  function automatic void ramp();
    for (int i = 0; i < 4704; i++) mem[i] = i;
  endfunction

  initial begin
    int cyc, ww;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    srst = 0;
    // random maps with two hand-planted windows
    for (int i = 0; i < 4704; i++) mem[i] = $urandom;
    mem[0] = 5;  mem[1] = -3; mem[28] = 7;  mem[29] = 2;
    mem[2] = -8; mem[3] = -1; mem[30] = -5; mem[31] = -9;
    build();
    chk("model_w0", exp_d[0], 7);
    chk("model_w1", exp_d[1], 32'hffffffff);
    run(1);
    chk("first_wr_addr", 32'(wlog_a[base_nw]), 8800);
    chk("first_wr_data", wlog_d[base_nw], 7);
    chk("second_wr_addr", 32'(wlog_a[base_nw + 1]), 8801);
    chk("second_wr_data", wlog_d[base_nw + 1], 32'hffffffff);
    // ramp with random read latency and stray valid pulses
    ramp();
    build();
    chk("model_ramp_first", exp_d[0], 29);
    chk("model_ramp_last", exp_d[1175], 4703);
    chk("model_ramp_last_addr", 32'(exp_a[1175]), 9975);
    lat_rand = 1;
    spur = 1;
    repeat (3) @(negedge clk);
    run(0);
    spur = 0;
    lat_rand = 0;
    repeat (3) @(negedge clk);
    chk("done_rises_b", drises, 2);
    // reset in the middle of the run after window 100
    base_nw = nw;
    enable = 1;
    @(negedge clk);
    enable = 0;
    cyc = 0;
    while (nw - base_nw < 100 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    chk("reached_window_100", nw - base_nw, 100);
    srst = 1;
    @(negedge clk);
    srst = 0;
    chk_zero("midrun_srst");
    ww = nw;
    repeat (10) @(negedge clk);
    chk("no_write_after_srst", nw, ww);
    chk("idle_after_srst_rd", dram_en_rd, 0);
    run(1);
    chk("done_rises_c", drises, 3);
    // enable while busy is ignored; enable in DONE restarts
    repeat (3) @(negedge clk);
    base_nw = nw;
    enable = 1;
    @(negedge clk);
    enable = 0;
    cyc = 0;
    while (!dram_en_rd && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    enable = 1;
    @(negedge clk);
    enable = 0;
    wait_done(cyc);
    chk("busy_enable_writes", nw - base_nw, 1176);
    enable = 1;
    @(negedge clk);
    enable = 0;
    base_nw = nw;
    chk("done_dropped", done, 0);
    chk("restart_rd", dram_en_rd, 1);
    chk("restart_addr", 32'(addr_in), 4096);
    wait_done(cyc);
    chk("restart_writes", nw - base_nw, 1176);
    chk("done_rises_d", drises, 5);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #(10 * 200000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
